o_buff_drain: RTL
=================

Name: o_buff_drain

Overview:
- Downstream of the PE wrapper.
- When the PE array raises ready, it captures the full array result (NUM_ROWS rows of NUM_PEs_PER_ROW lanes), then writes it row-by-row into the O buffer.
- Writes use a wrapping write pointer, per-lane write masks taken from the visible config, and honour O-buffer backpressure.
- Signals completion back to the wrapper's o_write state.

Parameters:
- DATA_WIDTH, 8: bits per PE result lane.
- NUM_PEs_PER_ROW, 4: lanes per row; equals one O-buffer word.
- NUM_ROWS, 4: rows per result burst.
- O_BUFF_DEPTH, 64: O-buffer words; need not be a power of two.
- O_ADDR_WIDTH, width(O_BUFF_DEPTH): address width.

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- result_valid  in  1  PE array ready
- result_ready  out  1  high only in IDLE
- result  in  NUM_ROWS*NUM_PEs_PER_ROW*DATA_WIDTH  array output; row r at bits [r*RW +: RW], RW = NUM_PEs_PER_ROW*DATA_WIDTH; lane p at [p*DATA_WIDTH +: DATA_WIDTH] within the row
- visible  in  NUM_ROWS*NUM_PEs_PER_ROW  lane-visible mask, same row/lane order
- ptr_load  in  1  load write pointer from base_addr
- base_addr  in  O_ADDR_WIDTH  pointer load value
- o_wr_en  out  1  O-buffer write request
- o_wr_ready  in  1  O-buffer accepts this cycle
- o_wr_addr  out  O_ADDR_WIDTH  write address
- o_wr_data  out  RW  row data
- o_wr_mask  out  NUM_PEs_PER_ROW  per-lane write enable
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse per completed burst
- wrap  out  1  one-cycle pulse when the pointer wraps to 0
- wr_ptr  out  O_ADDR_WIDTH  next free address

Interface decision: one clock; reset is asynchronous and active-low (ports clk, rst).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; wr_ptr=0; row counter=0.
  - All outputs 0 except result_ready=1.
  - Capture registers cleared.
  - Reset mid-burst abandons the burst; no done pulse.
- States: IDLE, WRITE, DONE.
- IDLE:
  - result_ready=1.
  - On result_valid: latch result and visible, row=0, go to WRITE next cycle.
  - If ptr_load and result_valid occur together, load wr_ptr=base_addr first; the burst starts at base_addr.
  - ptr_load is honoured only in IDLE and ignored otherwise.
- WRITE:
  - o_wr_en=1; o_wr_addr=wr_ptr; o_wr_data=latched row[row]; o_wr_mask=latched visible row slice.
  - Outputs are registered and held stable while o_wr_ready=0.
  - On o_wr_en && o_wr_ready:
    - wr_ptr <= (wr_ptr==O_BUFF_DEPTH-1) ? 0 : wr_ptr+1.
    - wrap pulses in the cycle after the wrap.
    - If row==NUM_ROWS-1, go to DONE; else row++.
  - Throughput: one row per cycle with o_wr_ready held high.
  - Latency: result_valid to first o_wr_en is 1 cycle; last accept to done is 1 cycle.
- DONE: done=1 for one cycle, then IDLE. result_ready=0 in WRITE and DONE; result_valid there is ignored.
- Overwrite: no overflow protection. Wrapping overwrites old O-buffer contents; wrap informs software.
- Row counter width: width(NUM_ROWS).

Optional Feature:
- Macro: O_DRAIN_SKIP_EMPTY_ROWS_EN.
- Defined:
  - A row whose visible slice is all zero is skipped: no o_wr_en, no pointer advance, zero cycles consumed.
  - Row selection uses a priority pick of the next non-empty row.
  - If all rows are empty, IDLE goes directly to DONE; done still pulses and wr_ptr is unchanged.
- Undefined: every row is written, including all-zero masks; pointer advances NUM_ROWS per burst.

Decomposition:
- Shared package/header (parameters.vh): DATA_WIDTH, NUM_PEs_PER_ROW, NUM_ROWS, O_BUFF_DEPTH defaults; state encodings IDLE=2'b00, WRITE=2'b01, DONE=2'b10; width() function.
- One natural sub-module: o_drain_ptr, the modulo-O_BUFF_DEPTH pointer with load, advance and wrap pulse.

Test Plan:
- Basic burst: reset, then result_valid with rows 0x01020304/0x05060708/0x090A0B0C/0x0D0E0F10, visible all ones, o_wr_ready=1 → writes at addr 0..3 on consecutive cycles, mask 4'hF; done 1 cycle after the last write; wr_ptr=4.
- Backpressure: o_wr_ready=0 for 3 cycles on row 1 → addr 1 and data held stable; total burst is 7 cycles; no duplicate writes.
- Wrap: ptr_load base_addr=62, burst → addresses 62, 63, 0, 1; wrap pulses once; wr_ptr=2.
- Mask and skip:
  - Row 2 visible=0, others 4'hA → without macro: 4 writes, row 2 mask 0.
  - With O_DRAIN_SKIP_EMPTY_ROWS_EN: 3 writes at addr 0, 1, 2 carrying rows 0, 1, 3.
- Reset mid-burst: assert rst low during row 2 → outputs 0 immediately; no done; wr_ptr=0. A new burst after release starts at addr 0.
- Ignored inputs: result_valid and ptr_load asserted during WRITE → no effect; result_ready=0 throughout.

Source files
------------

// File: rtl/o_buff_drain_pkg.sv
// Shared defaults, FSM encoding and width helper for the O-buffer drain.
// Used by o_buff_drain and o_drain_ptr.
package o_buff_drain_pkg;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_NUM_PES_PER_ROW = 4;
  localparam int DEF_NUM_ROWS        = 4;
  localparam int DEF_O_BUFF_DEPTH    = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/o_drain_ptr.sv
// Modulo-DEPTH write pointer for the O buffer: load, advance and a wrap pulse
// raised in the cycle after the pointer rolls over to 0.
module o_drain_ptr
  import o_buff_drain_pkg::*;
#(
  parameter int DEPTH = DEF_O_BUFF_DEPTH,
  parameter int AW    = width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic          advance,
  output logic [AW-1:0] ptr,
  output logic          wrap
);

  typedef logic [AW-1:0] addr_t;
  localparam addr_t LAST = addr_t'(DEPTH - 1);

  addr_t ptr_reg, ptr_next;
  logic  wrap_reg, wrap_next;

  // DEPTH need not be a power of two, so the rollover is an explicit compare.
  always_comb begin
    ptr_next  = ptr_reg;
    wrap_next = 1'b0;
    if (load) begin
      ptr_next = load_addr;
    end else if (advance) begin
      if (ptr_reg == LAST) begin
        ptr_next  = '0;
        wrap_next = 1'b1;
      end else begin
        ptr_next = ptr_reg + addr_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg  <= '0;
      wrap_reg <= 1'b0;
    end else begin
      ptr_reg  <= ptr_next;
      wrap_reg <= wrap_next;
    end
  end

  assign ptr  = ptr_reg;
  assign wrap = wrap_reg;

endmodule

// File: rtl/o_buff_drain.sv
// Captures one PE-array result burst and writes it row-by-row into the O buffer.
// Optional macro O_DRAIN_SKIP_EMPTY_ROWS_EN: rows with an all-zero visible mask are skipped.
module o_buff_drain
  import o_buff_drain_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int NUM_PEs_PER_ROW = DEF_NUM_PES_PER_ROW,
  parameter int NUM_ROWS        = DEF_NUM_ROWS,
  parameter int O_BUFF_DEPTH    = DEF_O_BUFF_DEPTH,
  parameter int O_ADDR_WIDTH    = width(O_BUFF_DEPTH)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           result_valid,
  output logic                                           result_ready,
  input  logic [NUM_ROWS*NUM_PEs_PER_ROW*DATA_WIDTH-1:0] result,
  input  logic [NUM_ROWS*NUM_PEs_PER_ROW-1:0]            visible,
  input  logic                                           ptr_load,
  input  logic [O_ADDR_WIDTH-1:0]                        base_addr,
  output logic                                           o_wr_en,
  input  logic                                           o_wr_ready,
  output logic [O_ADDR_WIDTH-1:0]                        o_wr_addr,
  output logic [NUM_PEs_PER_ROW*DATA_WIDTH-1:0]          o_wr_data,
  output logic [NUM_PEs_PER_ROW-1:0]                     o_wr_mask,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           wrap,
  output logic [O_ADDR_WIDTH-1:0]                        wr_ptr
);

  localparam int RW    = NUM_PEs_PER_ROW * DATA_WIDTH;
  localparam int ROW_W = width(NUM_ROWS);

  typedef logic [ROW_W-1:0] row_t;

  state_t                                state_reg, state_next;
  row_t                                  row_reg, row_next;
  logic [NUM_ROWS*RW-1:0]                result_reg;
  logic [NUM_ROWS*NUM_PEs_PER_ROW-1:0]   visible_reg;
  logic                                  capture;
  logic                                  accept;
  logic                                  ptr_load_idle;

  logic [RW-1:0]              row_data [NUM_ROWS];
  logic [NUM_PEs_PER_ROW-1:0] row_mask [NUM_ROWS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_rows
      assign row_data[gi] = result_reg[gi*RW +: RW];
      assign row_mask[gi] = visible_reg[gi*NUM_PEs_PER_ROW +: NUM_PEs_PER_ROW];
    end
  endgenerate

`ifdef O_DRAIN_SKIP_EMPTY_ROWS_EN
  logic [NUM_ROWS-1:0] in_nonempty;
  logic [NUM_ROWS-1:0] held_nonempty;
  logic                first_found, more_found;
  row_t                first_row, more_row;

  generate
    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_nonempty
      assign in_nonempty[gi]   = |visible[gi*NUM_PEs_PER_ROW +: NUM_PEs_PER_ROW];
      assign held_nonempty[gi] = |row_mask[gi];
    end
  endgenerate

  // Priority picks: lowest non-empty row of the incoming burst, and lowest
  // non-empty latched row above the one being written.
  always_comb begin
    first_found = 1'b0;
    first_row   = '0;
    more_found  = 1'b0;
    more_row    = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (in_nonempty[r]) begin
        first_found = 1'b1;
        first_row   = row_t'(r);
      end
      if (held_nonempty[r] && (row_t'(r) > row_reg)) begin
        more_found = 1'b1;
        more_row   = row_t'(r);
      end
    end
  end
`else
  localparam row_t LAST_ROW = row_t'(NUM_ROWS - 1);
`endif

  assign accept        = (state_reg == WRITE) && o_wr_ready;
  assign ptr_load_idle = ptr_load && (state_reg == IDLE);

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (result_valid) begin
          capture = 1'b1;
`ifdef O_DRAIN_SKIP_EMPTY_ROWS_EN
          row_next   = first_row;
          state_next = first_found ? WRITE : DONE;
`else
          row_next   = '0;
          state_next = WRITE;
`endif
        end
      end
      WRITE: begin
        if (o_wr_ready) begin
`ifdef O_DRAIN_SKIP_EMPTY_ROWS_EN
          if (more_found) begin
            row_next = more_row;
          end else begin
            row_next   = '0;
            state_next = DONE;
          end
`else
          if (row_reg == LAST_ROW) begin
            row_next   = '0;
            state_next = DONE;
          end else begin
            row_next = row_reg + row_t'(1);
          end
`endif
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      row_reg     <= '0;
      result_reg  <= '0;
      visible_reg <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      if (capture) begin
        result_reg  <= result;
        visible_reg <= visible;
      end
    end
  end

  o_drain_ptr #(
    .DEPTH (O_BUFF_DEPTH),
    .AW    (O_ADDR_WIDTH)
  ) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .load      (ptr_load_idle),
    .load_addr (base_addr),
    .advance   (accept),
    .ptr       (wr_ptr),
    .wrap      (wrap)
  );

  // Everything below is decoded straight from registers, so it stays put while stalled.
  assign o_wr_en      = (state_reg == WRITE);
  assign o_wr_addr    = o_wr_en ? wr_ptr : '0;
  assign o_wr_data    = o_wr_en ? row_data[row_reg] : '0;
  assign o_wr_mask    = o_wr_en ? row_mask[row_reg] : '0;
  assign result_ready = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);

endmodule
